rf_wr_arbiter: RTL

//  Shares the single write port of the 8x16 register file (R0 hard-wired zero, written on negedge clk)

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/rf_wr_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-port logic.
// The register file is 8x16 with R0 hard-wired to zero.
package rf_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 8;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 3'd0;

  // Write-port state: IDLE means nothing is on the port, ISSUE means a write is being presented
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] dest;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [RF_DEPTH-1:0] dest_onehot(input logic [RF_ADDR_W-1:0] dest);
    dest_onehot = '0;
    dest_onehot[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: searches upward from ptr, modulo N,
// and returns a one-hot grant for the first active request.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Outer loop walks priority order, inner loop keeps every bit select constant
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters with
// round-robin priority; write-port outputs are registered and sampled at negedge.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*RF_ADDR_W-1:0] req_dest,
  input  logic [NREQ*RF_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      arb_hold,
  output logic                      rg_wrt_enable,
  output logic [RF_ADDR_W-1:0]      rg_wrt_dest,
  output logic [RF_DATA_W-1:0]      rg_wrt_data,
  output logic [RF_DEPTH-1:0]       wr_pending,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] next_ptr;
  logic [NREQ-1:0]  req_masked;
  logic [NREQ-1:0]  gnt;
  logic             grant_any;
  logic             commit;
  wr_req_t          granted;
  logic [0:0]       state;

  assign req_masked = arb_hold ? '0 : req_valid;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req_masked),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Nothing may be handshaken while reset is held
  assign req_ready = rst ? gnt : '0;
  assign grant_any = |req_ready;

  always_comb begin
    winner  = '0;
    granted = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        winner       = PTR_W'(i);
        granted.dest = req_dest[i*RF_ADDR_W +: RF_ADDR_W];
        granted.data = req_data[i*RF_DATA_W +: RF_DATA_W];
      end
    end
  end

  assign next_ptr = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;

  // A grant to R0 is consumed like any other but never reaches the register file
  assign commit = grant_any && (granted.dest != RF_ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
      rr_ptr      <= '0;
      wr_count    <= '0;
    end else begin
      state <= commit ? ST_ISSUE : ST_IDLE;
      if (grant_any) begin
        rg_wrt_dest <= granted.dest;
        rg_wrt_data <= granted.data;
        rr_ptr      <= next_ptr;
      end
      if (commit && (wr_count != '1)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  assign rg_wrt_enable = (state == ST_ISSUE);
  assign wr_pending    = rg_wrt_enable ? dest_onehot(rg_wrt_dest) : '0;

endmodule
